// File: rtl/rv32i_core_if.sv
// ----------------------------------------------------------------------------
// rv32i_core_if
// Program-memory and data-memory bus of the rv32i_core. Both ports talk to
// synchronous byte-addressed memories: address/func3/write/data are sampled at
// the rising clock edge and read data comes back in the following cycle.
//
// Signals
//   pmAddress  [31:0]  instruction fetch byte address
//   pmFunc3    [2:0]   fetch access size (always word)
//   pmWrite            fetch write strobe (always 0)
//   pmDataCOut [31:0]  fetch write data (always 0)
//   pmDataCIn  [31:0]  fetched instruction
//   dmAddress  [31:0]  data byte address
//   dmFunc3    [2:0]   access size / signedness (instruction funct3)
//   dmWrite            store strobe
//   dmDataCOut [31:0]  store data, unshifted
//   dmDataCIn  [31:0]  load data, lane-aligned and extended by the memory
//
// Modports: master = core side, slave = memory side.
// ----------------------------------------------------------------------------
interface rv32i_core_if;
    logic [31:0] pmAddress;
    logic [2:0]  pmFunc3;
    logic        pmWrite;
    logic [31:0] pmDataCOut;
    logic [31:0] pmDataCIn;

    logic [31:0] dmAddress;
    logic [2:0]  dmFunc3;
    logic        dmWrite;
    logic [31:0] dmDataCOut;
    logic [31:0] dmDataCIn;

    modport master (
        output pmAddress, pmFunc3, pmWrite, pmDataCOut,
        input  pmDataCIn,
        output dmAddress, dmFunc3, dmWrite, dmDataCOut,
        input  dmDataCIn
    );

    modport slave (
        input  pmAddress, pmFunc3, pmWrite, pmDataCOut,
        output pmDataCIn,
        input  dmAddress, dmFunc3, dmWrite, dmDataCOut,
        output dmDataCIn
    );
endinterface

// File: rtl/rv32i_core.sv
// ----------------------------------------------------------------------------
// rv32i_core
// Single-issue RV32I integer core, Harvard bus. One instruction per clock,
// loads take two clocks. The instruction being executed is pmDataCIn itself;
// there is no internal instruction register, so pmAddress always carries the
// next pc and control flow has no penalty.
//
// Ports
//   clock  in   system clock, all state updates on rising edge
//   reset  in   synchronous active-high reset
//   bus    if   rv32i_core_if.master (program + data memory ports)
//
// FSM states
//   state      | meaning
//   S_EXEC     | normal execute; a load here issues its address and stalls pc
//   S_LOAD_WB  | load write-back; dmDataCIn goes to rd, pc advances
// ----------------------------------------------------------------------------
module rv32i_core #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic          clock,
    input  logic          reset,
    rv32i_core_if.master  bus
);

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    typedef enum logic {S_EXEC, S_LOAD_WB} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] rf_q [32];
    logic [31:0] rf_d [32];

    logic [31:0] instr;
    logic [6:0]  opcode;
    logic [4:0]  rd_idx, rs1_idx, rs2_idx;
    logic [2:0]  funct3;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic [31:0] rs1_val, rs2_val;
    logic [31:0] pc_plus4;
    logic [31:0] alu_b, alu_res;
    logic [4:0]  shamt;
    logic        br_taken;
    logic        rd_we;
    logic [31:0] rd_wdata;
    logic        store_en;

    // ------------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------------
    assign instr   = bus.pmDataCIn;
    assign opcode  = instr[6:0];
    assign rd_idx  = instr[11:7];
    assign funct3  = instr[14:12];
    assign rs1_idx = instr[19:15];
    assign rs2_idx = instr[24:20];

    assign imm_i = {{20{instr[31]}}, instr[31:20]};
    assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_u = {instr[31:12], 12'h000};
    assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

    // x0 is reset to zero and never written, so no read-side special case
    assign rs1_val  = rf_q[rs1_idx];
    assign rs2_val  = rf_q[rs2_idx];
    assign pc_plus4 = pc_q + 32'd4;

    // ------------------------------------------------------------------
    // ALU (shared by OP-IMM and OP)
    // ------------------------------------------------------------------
    assign alu_b = (opcode == OPC_OP) ? rs2_val : imm_i;
    assign shamt = alu_b[4:0];

    always_comb begin
        alu_res = '0;
        case (funct3)
            3'b000: alu_res = (opcode == OPC_OP && instr[30]) ? rs1_val - alu_b
                                                              : rs1_val + alu_b;
            3'b001: alu_res = rs1_val << shamt;
            3'b010: alu_res = {31'd0, $signed(rs1_val) < $signed(alu_b)};
            3'b011: alu_res = {31'd0, rs1_val < alu_b};
            3'b100: alu_res = rs1_val ^ alu_b;
            // instr[30] selects arithmetic shift for both SRAI and SRA
            3'b101: alu_res = instr[30] ? $unsigned($signed(rs1_val) >>> shamt)
                                        : rs1_val >> shamt;
            3'b110: alu_res = rs1_val | alu_b;
            default: alu_res = rs1_val & alu_b;
        endcase
    end

    always_comb begin
        br_taken = 1'b0;
        case (funct3)
            3'b000: br_taken = (rs1_val == rs2_val);
            3'b001: br_taken = (rs1_val != rs2_val);
            3'b100: br_taken = ($signed(rs1_val) <  $signed(rs2_val));
            3'b101: br_taken = ($signed(rs1_val) >= $signed(rs2_val));
            3'b110: br_taken = (rs1_val <  rs2_val);
            3'b111: br_taken = (rs1_val >= rs2_val);
            default: br_taken = 1'b0;
        endcase
    end

    // ------------------------------------------------------------------
    // Next-state / control
    // ------------------------------------------------------------------
    always_comb begin
        pc_d     = pc_plus4;
        state_d  = S_EXEC;
        rd_we    = 1'b0;
        rd_wdata = '0;
        store_en = 1'b0;
        case (opcode)
            OPC_LUI: begin
                rd_we    = 1'b1;
                rd_wdata = imm_u;
            end
            OPC_AUIPC: begin
                rd_we    = 1'b1;
                rd_wdata = pc_q + imm_u;
            end
            OPC_JAL: begin
                rd_we    = 1'b1;
                rd_wdata = pc_plus4;
                pc_d     = pc_q + imm_j;
            end
            OPC_JALR: begin
                rd_we    = 1'b1;
                rd_wdata = pc_plus4;
                pc_d     = (rs1_val + imm_i) & ~32'd1;
            end
            OPC_BRANCH: begin
                if (br_taken) pc_d = pc_q + imm_b;
            end
            OPC_LOAD: begin
                if (state_q == S_EXEC) begin
                    // re-fetch the same load so it is still on pmDataCIn
                    // during write-back
                    pc_d    = pc_q;
                    state_d = S_LOAD_WB;
                end else begin
                    rd_we    = 1'b1;
                    rd_wdata = bus.dmDataCIn;
                end
            end
            OPC_STORE: store_en = 1'b1;
            OPC_OPIMM, OPC_OP: begin
                rd_we    = 1'b1;
                rd_wdata = alu_res;
            end
            default: ;
        endcase
    end

    always_comb begin
        rf_d = rf_q;
        if (rd_we && rd_idx != 5'd0) rf_d[rd_idx] = rd_wdata;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pc_q    <= RESET_PC;
            state_q <= S_EXEC;
            for (int i = 0; i < 32; i++) rf_q[i] <= '0;
        end else begin
            pc_q    <= pc_d;
            state_q <= state_d;
            rf_q    <= rf_d;
        end
    end

    // ------------------------------------------------------------------
    // Bus outputs
    // ------------------------------------------------------------------
    assign bus.pmAddress  = reset ? RESET_PC : pc_d;
    assign bus.pmFunc3    = 3'b010;
    assign bus.pmWrite    = 1'b0;
    assign bus.pmDataCOut = '0;

    assign bus.dmAddress  = rs1_val + ((opcode == OPC_STORE) ? imm_s : imm_i);
    assign bus.dmFunc3    = funct3;
    assign bus.dmWrite    = store_en & ~reset;
    assign bus.dmDataCOut = rs2_val;

endmodule

// File: tb/tb_rv32i_core.sv
module tb_rv32i_core;

    localparam logic [6:0] OPI  = 7'h13;
    localparam logic [6:0] OPR  = 7'h33;
    localparam logic [6:0] LDO  = 7'h03;
    localparam logic [6:0] STO  = 7'h23;
    localparam logic [6:0] LUIO = 7'h37;
    localparam logic [6:0] JLRO = 7'h67;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic clk;
    logic rst;
    int   n_assert;
    int   n_fail;
    int   cyc;

    rv32i_core_if bus ();

    rv32i_core #(.RESET_PC(32'h0000_0000)) dut (
        .clock (clk),
        .reset (rst),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- memories ----------------
    logic [31:0] pmem [0:255];
    logic [7:0]  dmem [0:1023];

    function automatic logic [31:0] dm_read(input logic [31:0] a, input logic [2:0] f3);
        logic [9:0] ab;
        logic [9:0] hw;
        logic [9:0] wd;
        ab = a[9:0];
        hw = {ab[9:1], 1'b0};
        wd = {ab[9:2], 2'b00};
        case (f3)
            3'b000:  return {{24{dmem[ab][7]}}, dmem[ab]};
            3'b100:  return {24'd0, dmem[ab]};
            3'b001:  return {{16{dmem[hw+10'd1][7]}}, dmem[hw+10'd1], dmem[hw]};
            3'b101:  return {16'd0, dmem[hw+10'd1], dmem[hw]};
            default: return {dmem[wd+10'd3], dmem[wd+10'd2], dmem[wd+10'd1], dmem[wd]};
        endcase
    endfunction

    always @(posedge clk) begin
        bus.pmDataCIn <= pmem[bus.pmAddress[9:2]];
        if (bus.dmWrite) begin
            if (bus.dmAddress[31:10] == 22'd0) begin
                case (bus.dmFunc3)
                    3'b000: dmem[bus.dmAddress[9:0]] = bus.dmDataCOut[7:0];
                    3'b001: begin
                        dmem[{bus.dmAddress[9:1], 1'b0}] = bus.dmDataCOut[7:0];
                        dmem[{bus.dmAddress[9:1], 1'b1}] = bus.dmDataCOut[15:8];
                    end
                    default: begin
                        dmem[{bus.dmAddress[9:2], 2'b00}] = bus.dmDataCOut[7:0];
                        dmem[{bus.dmAddress[9:2], 2'b01}] = bus.dmDataCOut[15:8];
                        dmem[{bus.dmAddress[9:2], 2'b10}] = bus.dmDataCOut[23:16];
                        dmem[{bus.dmAddress[9:2], 2'b11}] = bus.dmDataCOut[31:24];
                    end
                endcase
            end
        end else begin
            bus.dmDataCIn <= dm_read(bus.dmAddress, bus.dmFunc3);
        end
    end

    // ---------------- encoders ----------------
    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd,
                                          input logic [6:0] op);
        return {imm, rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, OPR};
    endfunction

    function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3);
        return {imm[11:5], rs2, rs1, f3, imm[4:0], STO};
    endfunction

    function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3);
        return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'h63};
    endfunction

    function automatic logic [31:0] enc_u(input logic [19:0] imm, input logic [4:0] rd);
        return {imm, rd, LUIO};
    endfunction

    function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6F};
    endfunction

    // ---------------- helpers ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) pmem[i] = NOP;
        for (int i = 0; i < 1024; i++) dmem[i] = 8'h00;
    endtask

    task automatic hold_reset();
        rst = 1'b1;
        tick();
        tick();
    endtask

    task automatic release_reset();
        rst = 1'b0;
        #1;
    endtask

    // Advances until a store strobe is visible; cycles = clocks advanced.
    task automatic run_until_store(output int cycles);
        cycles = 0;
        while (bus.dmWrite !== 1'b1 && cycles < 50) begin
            tick();
            cycles++;
        end
        check("store_seen", {31'd0, bus.dmWrite}, 32'd1);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        n_assert = 0;
        n_fail   = 0;
        rst      = 1'b1;

        // ===== program 1: reset/fetch, ALU, x0 =====
        clear_mem();
        pmem[0]  = enc_i(12'h400, 5'd0, 3'b000, 5'd1, OPI);   // ADDI x1,x0,0x400
        pmem[1]  = enc_i(12'hFFF, 5'd0, 3'b000, 5'd2, OPI);   // ADDI x2,x0,-1
        pmem[2]  = enc_i(12'h01C, 5'd2, 3'b101, 5'd3, OPI);   // SRLI x3,x2,28
        pmem[3]  = enc_i(12'h41C, 5'd2, 3'b101, 5'd4, OPI);   // SRAI x4,x2,28
        pmem[4]  = enc_r(7'h00, 5'd2, 5'd0, 3'b011, 5'd5);    // SLTU x5,x0,x2
        pmem[5]  = enc_r(7'h20, 5'd2, 5'd0, 3'b000, 5'd6);    // SUB x6,x0,x2
        pmem[6]  = enc_s(12'h000, 5'd1, 5'd0, 3'b010);        // SW x1,0(x0)
        pmem[7]  = enc_s(12'h004, 5'd3, 5'd0, 3'b010);        // SW x3,4(x0)
        pmem[8]  = enc_s(12'h008, 5'd4, 5'd0, 3'b010);        // SW x4,8(x0)
        pmem[9]  = enc_s(12'h00C, 5'd5, 5'd0, 3'b010);        // SW x5,12(x0)
        pmem[10] = enc_s(12'h010, 5'd6, 5'd0, 3'b010);        // SW x6,16(x0)
        pmem[11] = enc_i(12'h005, 5'd0, 3'b000, 5'd0, OPI);   // ADDI x0,x0,5
        pmem[12] = enc_s(12'h014, 5'd0, 5'd0, 3'b010);        // SW x0,20(x0)
        pmem[13] = enc_j(21'd0, 5'd0);                        // JAL x0,0
        hold_reset();
        check("rst_pmaddr", bus.pmAddress, 32'h0);
        check("rst_dmwrite", {31'd0, bus.dmWrite}, 32'd0);
        release_reset();
        check("first_pmaddr", bus.pmAddress, 32'h4);
        run_until_store(cyc);
        check("p1_store_cycles", cyc, 32'd6);
        check("x1_addr", bus.dmAddress, 32'h0);
        check("x1_val", bus.dmDataCOut, 32'h0000_0400);
        tick();
        check("x3_addr", bus.dmAddress, 32'h4);
        check("x3_srli", bus.dmDataCOut, 32'h0000_000F);
        tick();
        check("x4_srai", bus.dmDataCOut, 32'hFFFF_FFFF);
        tick();
        check("x5_sltu", bus.dmDataCOut, 32'h1);
        tick();
        check("x6_sub", bus.dmDataCOut, 32'h1);
        tick();
        tick();
        check("x0_store_addr", bus.dmAddress, 32'h14);
        check("x0_zero", bus.dmDataCOut, 32'h0);

        // ===== program 2: load/store lanes and load timing =====
        rst = 1'b1;
        clear_mem();
        pmem[0]  = enc_u(20'h80402, 5'd1);                    // LUI x1,0x80402
        pmem[1]  = enc_i(12'h010, 5'd1, 3'b000, 5'd1, OPI);   // ADDI x1,x1,0x10
        pmem[2]  = enc_s(12'h100, 5'd1, 5'd0, 3'b010);        // SW x1,0x100(x0)
        pmem[3]  = enc_i(12'h103, 5'd0, 3'b000, 5'd2, LDO);   // LB  x2,0x103
        pmem[4]  = enc_i(12'h103, 5'd0, 3'b100, 5'd3, LDO);   // LBU x3,0x103
        pmem[5]  = enc_i(12'h102, 5'd0, 3'b001, 5'd4, LDO);   // LH  x4,0x102
        pmem[6]  = enc_i(12'h100, 5'd0, 3'b010, 5'd5, LDO);   // LW  x5,0x100
        pmem[7]  = enc_s(12'h200, 5'd2, 5'd0, 3'b010);
        pmem[8]  = enc_s(12'h204, 5'd3, 5'd0, 3'b010);
        pmem[9]  = enc_s(12'h208, 5'd4, 5'd0, 3'b010);
        pmem[10] = enc_s(12'h20C, 5'd5, 5'd0, 3'b010);
        pmem[11] = enc_j(21'd0, 5'd0);
        hold_reset();
        release_reset();
        run_until_store(cyc);
        check("sw_cycles", cyc, 32'd2);
        check("sw_addr", bus.dmAddress, 32'h100);
        check("sw_data", bus.dmDataCOut, 32'h8040_2010);
        check("sw_func3", {29'd0, bus.dmFunc3}, 32'd2);
        tick();
        check("lb_c1_dmwrite", {31'd0, bus.dmWrite}, 32'd0);
        check("lb_c1_refetch", bus.pmAddress, 32'hC);
        check("lb_c1_addr", bus.dmAddress, 32'h103);
        check("lb_c1_func3", {29'd0, bus.dmFunc3}, 32'd0);
        tick();
        check("lb_c2_pmaddr", bus.pmAddress, 32'h10);
        tick();
        check("lbu_c1_refetch", bus.pmAddress, 32'h10);
        run_until_store(cyc);
        check("loads_cycles", cyc, 32'd6);
        check("lb_val", bus.dmDataCOut, 32'hFFFF_FF80);
        tick();
        check("lbu_val", bus.dmDataCOut, 32'h0000_0080);
        tick();
        check("lh_val", bus.dmDataCOut, 32'hFFFF_8040);
        tick();
        check("lw_addr", bus.dmAddress, 32'h20C);
        check("lw_val", bus.dmDataCOut, 32'h8040_2010);

        // ===== program 3: JAL / BNE loop / JALR =====
        rst = 1'b1;
        clear_mem();
        pmem[0] = enc_i(12'h003, 5'd0, 3'b000, 5'd2, OPI);    // ADDI x2,x0,3
        pmem[1] = enc_j(21'd16, 5'd1);                        // JAL x1,+16
        pmem[2] = enc_s(12'h040, 5'd1, 5'd0, 3'b010);         // SW x1,0x40
        pmem[3] = enc_s(12'h044, 5'd3, 5'd0, 3'b010);         // SW x3,0x44
        pmem[4] = enc_j(21'd0, 5'd0);                         // JAL x0,0
        pmem[5] = enc_i(12'hFFF, 5'd2, 3'b000, 5'd2, OPI);    // ADDI x2,x2,-1
        pmem[6] = enc_i(12'h001, 5'd3, 3'b000, 5'd3, OPI);    // ADDI x3,x3,1
        pmem[7] = enc_b(13'h1FF8, 5'd0, 5'd2, 3'b001);        // BNE x2,x0,-8
        pmem[8] = enc_i(12'h000, 5'd1, 3'b000, 5'd0, JLRO);   // JALR x0,0(x1)
        hold_reset();
        release_reset();
        tick();
        check("jal_target", bus.pmAddress, 32'h14);
        tick(); tick(); tick();
        check("bne_taken", bus.pmAddress, 32'h14);
        for (int i = 0; i < 6; i++) tick();
        check("bne_exit", bus.pmAddress, 32'h20);
        tick();
        check("jalr_target", bus.pmAddress, 32'h8);
        tick();
        check("ra_store_seen", {31'd0, bus.dmWrite}, 32'd1);
        check("jal_link", bus.dmDataCOut, 32'h8);
        tick();
        check("loop_count", bus.dmDataCOut, 32'h3);

        // ===== program 4: MMIO store, reset mid-load =====
        rst = 1'b1;
        clear_mem();
        pmem[0] = enc_u(20'hF0000, 5'd10);                    // LUI x10,0xF0000
        pmem[1] = enc_i(12'h041, 5'd0, 3'b000, 5'd11, OPI);   // ADDI x11,x0,'A'
        pmem[2] = enc_s(12'h010, 5'd11, 5'd10, 3'b010);       // SW x11,16(x10)
        pmem[3] = enc_i(12'h000, 5'd0, 3'b010, 5'd12, LDO);   // LW x12,0(x0)
        pmem[4] = enc_s(12'h030, 5'd12, 5'd0, 3'b010);        // SW x12,0x30
        pmem[5] = enc_j(21'd0, 5'd0);
        dmem[0] = 8'hEF; dmem[1] = 8'hBE; dmem[2] = 8'hAD; dmem[3] = 8'hDE;
        hold_reset();
        release_reset();
        run_until_store(cyc);
        check("mmio_cycles", cyc, 32'd2);
        check("mmio_addr", bus.dmAddress, 32'hF000_0010);
        check("mmio_char", {25'd0, bus.dmDataCOut[6:0]}, 32'h41);
        tick();
        check("mmio_one_cycle", {31'd0, bus.dmWrite}, 32'd0);
        check("ld_c1_refetch", bus.pmAddress, 32'hC);
        rst = 1'b1;
        #1;
        check("midload_rst_pmaddr", bus.pmAddress, 32'h0);
        tick();
        check("midload_rst_dmwrite", {31'd0, bus.dmWrite}, 32'd0);
        tick();
        release_reset();
        check("after_rst_pmaddr", bus.pmAddress, 32'h4);
        tick();
        check("after_rst_x11_src", bus.pmAddress, 32'h8);
        tick();
        check("rerun_mmio_data", bus.dmDataCOut, 32'h41);
        tick();
        run_until_store(cyc);
        check("rerun_load_cycles", cyc, 32'd2);
        check("rerun_lw_addr", bus.dmAddress, 32'h30);
        check("rerun_lw_val", bus.dmDataCOut, 32'hDEAD_BEEF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/rv32i_core.md
Name: rv32i_core

Overview:
- Single-issue RV32I integer CPU with separate program-memory and data-memory ports (Harvard).
- Both ports drive synchronous byte-addressed memories.
- A memory samples address/func3/write/data at the rising clock edge and returns read data in the following cycle.
- The core executes one instruction per clock; loads take two clocks. The UART and other MMIO devices live on the data port.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
clock  in  1  system clock; all state updates on rising edge
reset  in  1  synchronous, active-high reset
pmAddress  out  32  instruction fetch byte address (= pc_next, combinational)
pmFunc3  out  3  fetch access size; constant 3'b010 (word)
pmWrite  out  1  constant 0
pmDataCOut  out  32  constant 0
pmDataCIn  in  32  instruction fetched from the previous cycle's pmAddress
dmAddress  out  32  data byte address, rs1 + imm (combinational)
dmFunc3  out  3  instruction funct3 (LB=0, LH=1, LW=2, LBU=4, LHU=5; SB=0, SH=1, SW=2)
dmWrite  out  1  store strobe, combinational, high for one cycle per store
dmDataCOut  out  32  store data = rs2, unshifted; memory selects lanes by address[1:0] and func3
dmDataCIn  in  32  load data, already lane-aligned and sign/zero-extended by the memory per func3

Behaviour:
- State: pc (32b), load_pending (1b), regfile x1..x31 (32b each); x0 reads 0 and writes to it are discarded.
- Reset (synchronous, sampled at posedge):
  - pc <= RESET_PC, load_pending <= 0, all registers <= 0.
  - While reset is high: pmAddress = RESET_PC, dmWrite = 0.
  - First cycle after reset falls: pmDataCIn holds the instruction at RESET_PC and it executes.
- Instruction register: the current instruction is pmDataCIn, with no internal IR.
- pc_next is driven on pmAddress every cycle and gives zero-penalty control flow:
  - pc + 4 by default.
  - Branch target when a branch is taken.
  - JAL: pc + imm.
  - JALR: (rs1 + imm) & ~1.
- Arithmetic:
  - All arithmetic is 32-bit wrapping.
  - Shifts use rs2[4:0] / shamt.
  - SLT/SLTI compare signed; SLTU/SLTIU compare unsigned.
  - Immediates are sign-extended per the RISC-V I/S/B/U/J formats.
- Supported instructions:
  - LUI, AUIPC, JAL, JALR (rd <= pc + 4).
  - BEQ/BNE/BLT/BGE/BLTU/BGEU.
  - LB/LH/LW/LBU/LHU and SB/SH/SW.
  - ADDI/SLTI/SLTIU/XORI/ORI/ANDI/SLLI/SRLI/SRAI.
  - ADD/SUB/SLL/SLT/SLTU/XOR/SRL/SRA/OR/AND.
- FENCE, ECALL, EBREAK and unknown opcodes execute as NOP (pc + 4, no writes).
- Store: one cycle.
  - dmWrite = 1, dmAddress = rs1 + imm_s, dmDataCOut = rs2, dmFunc3 = funct3.
  - The write commits at the end of that cycle.
- Load: two cycles.
  - Cycle 1 (load_pending = 0): drive dmAddress = rs1 + imm_i and dmFunc3 = funct3.
  - Cycle 1: pmAddress = pc (re-fetch of the same instruction), pc holds, load_pending <= 1.
  - Cycle 2 (load_pending = 1): rd <= dmDataCIn, pmAddress = pc + 4, pc advances, load_pending <= 0.
- Register write-back occurs at posedge; a read of a register in the cycle after its write sees the new value.
- Misalignment is not trapped:
  - The memory ignores address[1:0] for word accesses and address[0] for halfwords.
  - JALR target bit 0 is cleared.
- Reset asserted mid-load aborts the load: no register write, load_pending cleared.

Test Plan:
- Reset/fetch: reset high two cycles, memory word0 = ADDI x1,x0,0x400 -> pmAddress = 0 during reset; x1 = 0x400 after the first post-reset cycle; pmAddress = 4.
- ALU: ADDI x2,x0,-1; SRLI x3,x2,28; SRAI x4,x2,28; SLTU x5,x0,x2; SUB x6,x0,x2 -> x3 = 0xF, x4 = 0xFFFFFFFF, x5 = 1, x6 = 1.
- Load/store: SW 0x80402010 to 0x100; LB/LBU/LH/LW from 0x103/0x103/0x102/0x100 -> 0xFFFFFF80, 0x80, 0xFFFF8040, 0x80402010; each load occupies exactly 2 cycles.
- Control flow: JAL x1,+16 at pc = 4 -> x1 = 8, next pmAddress = 0x14; BNE loop counting 3->0 exits after 3 iterations; JALR x0,0(x1) returns to 8.
- MMIO: LUI x10,0xF0000; ADDI x11,x0,'A'; SW x11,16(x10) -> dmWrite = 1 for exactly one cycle with dmAddress = 0xF0000010, dmDataCOut[6:0] = 0x41.
- x0 and reset-mid-load: ADDI x0,x0,5 leaves x0 = 0; reset asserted in load cycle 1 -> rd unchanged, pc = 0.
